// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Each access runs SETUP, WAIT_CYCLES of STROBE, then HOLD (the done cycle).
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [15:0] ifAddr,
  input  logic [1:0]  memControl,
  input  logic [15:0] memAddr,
  input  logic [15:0] memWdata,
  output logic        ifDone,
  output logic [15:0] ifData,
  output logic        memDone,
  output logic [15:0] memRdata,
  output logic        stall,
  output logic [15:0] ramAddr,
  output logic [15:0] ramWdata,
  output logic        ramCE,
  output logic        ramOE,
  output logic        ramWE,
  output logic        ramDrive,
  input  logic [15:0] ramRdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    STROBE = 2'b10,
    HOLD   = 2'b11
  } state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        fetch_waited_r, fetch_waited_s;
  logic        who_r, who_s;
  logic        wr_r, wr_s;
  logic [15:0] addr_s, wdata_s;
  logic        cap_s;
  logic        data_req_s, if_pend_s, mem_pend_s;
  logic        ce_s, oe_s, we_s, drive_s, if_done_s, mem_done_s;

  // A requester is still asserting during its own HOLD cycle, so exclude it there.
  always_comb begin
    data_req_s = (memControl == 2'b10) || (memControl == 2'b01);
    if_pend_s  = ifReq && !((state_r == HOLD) && who_r);
    mem_pend_s = data_req_s && !((state_r == HOLD) && !who_r);
  end

  // Next-state, arbitration and latch of the granted request.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    fetch_waited_s = fetch_waited_r;
    who_s          = who_r;
    wr_s           = wr_r;
    addr_s         = ramAddr;
    wdata_s        = ramWdata;
    cap_s          = 1'b0;
    case (state_r)
      IDLE, HOLD: begin
        if (mem_pend_s && !(fetch_waited_r && if_pend_s)) begin
          state_s        = SETUP;
          who_s          = 1'b0;
          wr_s           = (memControl == 2'b01);
          addr_s         = memAddr;
          wdata_s        = memWdata;
          fetch_waited_s = fetch_waited_r || ifReq;
        end else if (if_pend_s) begin
          state_s        = SETUP;
          who_s          = 1'b1;
          wr_s           = 1'b0;
          addr_s         = ifAddr;
          fetch_waited_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s = STROBE;
        cnt_s   = STROBE_LOAD;
      end
      STROBE: begin
        if (cnt_r == 4'd0) begin
          state_s = HOLD;
          cap_s   = !wr_r;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // RAM strobes and done pulses are decoded from the next state so they leave a flop.
  always_comb begin
    ce_s       = (state_s != IDLE);
    oe_s       = (state_s == STROBE) && !wr_s;
    we_s       = (state_s == STROBE) && wr_s;
    drive_s    = ce_s && wr_s;
    if_done_s  = (state_s == HOLD) && who_s;
    mem_done_s = (state_s == HOLD) && !who_s;
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      fetch_waited_r <= 1'b0;
      who_r          <= 1'b0;
      wr_r           <= 1'b0;
      ramAddr        <= 16'hFFFF;
      ramWdata       <= 16'h0000;
      ramCE          <= 1'b0;
      ramOE          <= 1'b0;
      ramWE          <= 1'b0;
      ramDrive       <= 1'b0;
      ifDone         <= 1'b0;
      memDone        <= 1'b0;
      ifData         <= 16'h0000;
      memRdata       <= 16'h0000;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      fetch_waited_r <= fetch_waited_s;
      who_r          <= who_s;
      wr_r           <= wr_s;
      ramAddr        <= addr_s;
      ramWdata       <= wdata_s;
      ramCE          <= ce_s;
      ramOE          <= oe_s;
      ramWE          <= we_s;
      ramDrive       <= drive_s;
      ifDone         <= if_done_s;
      memDone        <= mem_done_s;
      if (cap_s && who_r) begin
        ifData <= ramRdata;
      end
      if (cap_s && !who_r) begin
        memRdata <= ramRdata;
      end
    end
  end

  assign stall = rst && ((ifReq && !ifDone) || (data_req_s && !memDone));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with WAIT_CYCLES=2; requesters are modelled
// as holding their request until the matching done pulse.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ifReq;
  logic [15:0] ifAddr;
  logic [1:0]  memControl;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        ifDone;
  logic [15:0] ifData;
  logic        memDone;
  logic [15:0] memRdata;
  logic        stall;
  logic [15:0] ramAddr;
  logic [15:0] ramWdata;
  logic        ramCE;
  logic        ramOE;
  logic        ramWE;
  logic        ramDrive;
  logic [15:0] ramRdata;

  int total = 0;
  int bad   = 0;

  int ce_cnt, oe_cnt, we_cnt, drv_cnt, stall_cnt, if_cnt, mem_cnt, both_cnt;
  int if_at, mem_at;
  logic keep_if, keep_mem;
  logic prev_ce, prev_done;
  logic [15:0] order_q[$];

  mem_port_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ifReq(ifReq), .ifAddr(ifAddr),
    .memControl(memControl), .memAddr(memAddr), .memWdata(memWdata),
    .ifDone(ifDone), .ifData(ifData), .memDone(memDone), .memRdata(memRdata),
    .stall(stall), .ramAddr(ramAddr), .ramWdata(ramWdata),
    .ramCE(ramCE), .ramOE(ramOE), .ramWE(ramWE), .ramDrive(ramDrive),
    .ramRdata(ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0; stall_cnt = 0;
    if_cnt = 0; mem_cnt = 0; both_cnt = 0; if_at = 0; mem_at = 0;
    prev_ce = 1'b0; prev_done = 1'b0;
    order_q.delete();
  endtask

  // Observe n cycles just after each falling edge; drop a request once its done is seen.
  task automatic run(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      #1;
      if (ramCE && (!prev_ce || prev_done)) order_q.push_back(ramAddr);
      if (ramCE) ce_cnt++;
      if (ramOE) oe_cnt++;
      if (ramWE) we_cnt++;
      if (ramDrive) drv_cnt++;
      if (stall) stall_cnt++;
      if (ifDone && memDone) both_cnt++;
      prev_ce   = ramCE;
      prev_done = ifDone || memDone;
      if (ifDone) begin
        if_cnt++;
        if_at = c;
        if (!keep_if) ifReq = 1'b0;
      end
      if (memDone) begin
        mem_cnt++;
        mem_at = c;
        if (!keep_mem) memControl = 2'b00;
      end
    end
  endtask

  initial begin
    rst = 1'b0; ifReq = 1'b1; ifAddr = 16'h0000; memControl = 2'b00;
    memAddr = 16'h0000; memWdata = 16'h0000; ramRdata = 16'h0000;
    keep_if = 1'b0; keep_mem = 1'b0;
    clr();
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ramAddr", 32'(ramAddr), 32'h0000FFFF);
    chk("rst_ramCE", 32'(ramCE), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ifData", 32'(ifData), 32'd0);
    chk("rst_memRdata", 32'(memRdata), 32'd0);
    chk("rst_ifDone", 32'(ifDone), 32'd0);
    ifReq = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;

    // Fetch read from 0040
    clr();
    ifReq = 1'b1; ifAddr = 16'h0040; ramRdata = 16'h1234;
    #1;
    chk("fetch_stall_pre", 32'(stall), 32'd1);
    run(6);
    chk("fetch_oe_cycles", 32'(oe_cnt), 32'd2);
    chk("fetch_we_cycles", 32'(we_cnt), 32'd0);
    chk("fetch_done_count", 32'(if_cnt), 32'd1);
    chk("fetch_done_cycle", 32'(if_at), 32'd4);
    chk("fetch_ifData", 32'(ifData), 32'h00001234);
    chk("fetch_no_memDone", 32'(mem_cnt), 32'd0);
    chk("fetch_addr", 32'(order_q.size() > 0 ? order_q[0] : 16'hDEAD), 32'h00000040);

    // Data write BEEF to 0100
    clr();
    memControl = 2'b01; memAddr = 16'h0100; memWdata = 16'hBEEF;
    run(6);
    chk("write_we_cycles", 32'(we_cnt), 32'd2);
    chk("write_drive_cycles", 32'(drv_cnt), 32'd4);
    chk("write_oe_cycles", 32'(oe_cnt), 32'd0);
    chk("write_ramWdata", 32'(ramWdata), 32'h0000BEEF);
    chk("write_done_count", 32'(mem_cnt), 32'd1);
    chk("write_done_cycle", 32'(mem_at), 32'd4);
    chk("write_ifData_kept", 32'(ifData), 32'h00001234);
    chk("write_memRdata_kept", 32'(memRdata), 32'd0);

    // Contention: data read 0200 and fetch 0040 together
    clr();
    ifReq = 1'b1; ifAddr = 16'h0040; memControl = 2'b10; memAddr = 16'h0200;
    ramRdata = 16'h5678;
    run(10);
    chk("cont_mem_done_cycle", 32'(mem_at), 32'd4);
    chk("cont_if_done_cycle", 32'(if_at), 32'd8);
    chk("cont_stall_cycles", 32'(stall_cnt), 32'd7);
    chk("cont_memRdata", 32'(memRdata), 32'h00005678);
    chk("cont_both_done", 32'(both_cnt), 32'd0);
    chk("cont_first", 32'(order_q.size() > 0 ? order_q[0] : 16'hDEAD), 32'h00000200);
    chk("cont_second", 32'(order_q.size() > 1 ? order_q[1] : 16'hDEAD), 32'h00000040);

    // Fairness: both requesters continuously active
    clr();
    keep_if = 1'b1; keep_mem = 1'b1;
    ifReq = 1'b1; ifAddr = 16'h0050; memControl = 2'b10; memAddr = 16'h0300;
    run(16);
    chk("fair_g0", 32'(order_q.size() > 0 ? order_q[0] : 16'hDEAD), 32'h00000300);
    chk("fair_g1", 32'(order_q.size() > 1 ? order_q[1] : 16'hDEAD), 32'h00000050);
    chk("fair_g2", 32'(order_q.size() > 2 ? order_q[2] : 16'hDEAD), 32'h00000300);
    chk("fair_g3", 32'(order_q.size() > 3 ? order_q[3] : 16'hDEAD), 32'h00000050);
    chk("fair_both_done", 32'(both_cnt), 32'd0);
    keep_if = 1'b0; keep_mem = 1'b0; ifReq = 1'b0;
    run(8);

    // Reset during the STROBE phase of a write
    clr();
    memControl = 2'b01; memAddr = 16'h0400; memWdata = 16'hCAFE;
    run(2);
    chk("rstmid_we_before", 32'(ramWE), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_we_async", 32'(ramWE), 32'd0);
    chk("rstmid_drive", 32'(ramDrive), 32'd0);
    chk("rstmid_ramAddr", 32'(ramAddr), 32'h0000FFFF);
    chk("rstmid_stall", 32'(stall), 32'd0);
    run(2);
    chk("rstmid_no_done", 32'(mem_cnt), 32'd0);
    rst = 1'b1;
    clr();
    run(6);
    chk("rstmid_restart_addr", 32'(order_q.size() > 0 ? order_q[0] : 16'hDEAD), 32'h00000400);
    chk("rstmid_restart_done", 32'(mem_at), 32'd4);
    chk("rstmid_restart_we", 32'(we_cnt), 32'd2);
    chk("rstmid_ramWdata", 32'(ramWdata), 32'h0000CAFE);

    // memControl=11 is no request
    clr();
    memControl = 2'b11; ifReq = 1'b0;
    #1;
    chk("nop_stall", 32'(stall), 32'd0);
    run(4);
    chk("nop_ce_cycles", 32'(ce_cnt), 32'd0);
    chk("nop_strobes", 32'(oe_cnt + we_cnt), 32'd0);
    chk("nop_done", 32'(mem_cnt + if_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning RAM strobe length in cycles (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port ifReq, input, 1 bit, an instruction-fetch request level.
REQ-005 The block SHALL have port ifAddr, input, 16 bits, the fetch address.
REQ-006 The block SHALL have port memControl, input, 2 bits, the data request: 10 read, 01 write, 00 and 11 none.
REQ-007 The block SHALL have ports memAddr and memWdata, inputs, 16 bits each, the data address and write data.
REQ-008 The block SHALL have ports ifDone and ifData, outputs, 1 and 16 bits, the fetch completion pulse and fetched word.
REQ-009 The block SHALL have ports memDone and memRdata, outputs, 1 and 16 bits, the data completion pulse and read word.
REQ-010 The block SHALL have port stall, output, 1 bit, the pipeline hold.
REQ-011 The block SHALL have ports ramAddr and ramWdata, outputs, 16 bits each, the RAM address and write data.
REQ-012 The block SHALL have ports ramCE, ramOE, ramWE and ramDrive, outputs, 1 bit each, active-high RAM strobes and the write-data bus drive enable.
REQ-013 The block SHALL have port ramRdata, input, 16 bits, the RAM read data.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD.
REQ-015 In IDLE or HOLD with a pending request, the block SHALL grant, latch the op/addr/wdata into internal registers, and go to SETUP next cycle; otherwise it SHALL go to IDLE.
REQ-016 Arbitration: a data request SHALL beat ifReq, except when the fetchWaited flag is set; then fetch SHALL win.
REQ-017 fetchWaited SHALL set when data is granted while ifReq=1, and SHALL clear on any fetch grant.
REQ-018 SETUP SHALL last 1 cycle; STROBE SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter; HOLD SHALL last 1 cycle.
REQ-019 ramAddr SHALL hold the latched address from SETUP through HOLD.
REQ-020 ramCE SHALL be 1 in SETUP, STROBE and HOLD.
REQ-021 ramOE SHALL be 1 in STROBE for reads only.
REQ-022 ramWE SHALL be 1 in STROBE for writes only.
REQ-023 ramDrive SHALL be 1 with ramWdata stable in SETUP–HOLD for writes only.
REQ-024 On a read, ramRdata SHALL be registered on the last STROBE cycle into ifData or memRdata (by grantee); the other data output SHALL keep its value.
REQ-025 ifDone or memDone SHALL pulse for exactly the HOLD cycle of the corresponding grant; both SHALL never be high together.
REQ-026 Latency SHALL be WAIT_CYCLES+2 cycles from grant edge to done cycle; back-to-back grants SHALL have no idle gap.
REQ-027 stall SHALL be combinational: 1 when (ifReq or memControl in {01,10}) and the current cycle is not the done cycle for every asserted request.
REQ-028 Requesters SHALL hold requests until their done; input changes after grant SHALL have no effect on the access in flight.
REQ-029 memControl=11 SHALL be treated as no request and SHALL have no other effect.

Reset
REQ-030 While rst=0, at any time including mid-access, the FSM SHALL be IDLE and counter and fetchWaited SHALL be 0.
REQ-031 While rst=0, all strobes, ramDrive, ifDone, memDone and stall SHALL be 0; ramAddr SHALL be FFFF and all data outputs 0000.
REQ-032 No done pulse SHALL be issued for an access aborted by reset.

Verification
REQ-033 Fetch read: ifReq=1, ifAddr=0040, RAM returns 1234, WAIT_CYCLES=2 -> ramOE high 2 cycles; ifDone pulses on the 4th cycle after grant; ifData=1234.
REQ-034 Data write: memControl=01, memAddr=0100, memWdata=BEEF -> ramWE high exactly 2 cycles; ramDrive on SETUP–HOLD; ramWdata=BEEF; memDone pulses once; ramOE stays 0.
REQ-035 Contention: ifReq=1 and memControl=10 together -> data served first, then fetch granted in the data HOLD cycle; memDone and ifDone pulses are 4 cycles apart; stall is held until ifDone.
REQ-036 Fairness: continuous data reads with ifReq=1 -> grants alternate data, fetch, data, fetch.
REQ-037 Reset mid-STROBE of a write -> ramWE drops asynchronously, no memDone, ramAddr=FFFF; after release with requests held, the request restarts from SETUP.
REQ-038 memControl=11 with ifReq=0 -> FSM stays IDLE, stall=0, no strobes.
